mini_alu_core: RTL and testbench
================================

# mini_alu_core

Parametrised, two-stage (fetch/execute) accumulator-free register machine that replaces the fixed 16-bit mini ALU datapath. It fetches from an external asynchronous instruction ROM, executes against an internal register file, and drives LEDs plus a byte-wide peripheral port (LCD writer) through a proper valid/ready stall instead of rewinding the instruction pointer. It adds logic/shift/compare ops, BEQ, and HALT.

## Interface
- DATA_W, 16, register/ALU width (≥8)
- ADDR_W, 8, register-address field width; register file depth = 2**ADDR_W
- IP_W, 16, instruction-pointer width (≥ADDR_W)
- INSN_W (localparam) = 4 + 3*ADDR_W; fields: opcode[INSN_W-1 -: 4], dest[3*ADDR_W-1 -: ADDR_W], src1[2*ADDR_W-1 -: ADDR_W], src0[ADDR_W-1:0]
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; clears all state listed below
- oIP  out  IP_W  instruction address to ROM
- iInstruction  in  INSN_W  ROM data for oIP (combinational ROM)
- oLed  out  8  LED register
- oPeriphData  out  8  byte to peripheral
- oPeriphValid  out  1  byte pending
- iPeriphReady  in  1  peripheral accepts byte
- oHalted  out  1  core stopped on HALT

## Operation
- IR: instruction register; IP: fetch pointer. Fetch each non-stalled edge: IR <= iInstruction, IP <= IP+1 (wraps mod 2**IP_W).
- Execute on IR; operands A = R[src1], B = R[src0], read combinationally; write R[dest] at edge end of execute. No forwarding needed (write lands before next instruction reads).
- Opcodes: 0 NOP; 1 ADD A+B; 2 SUB A−B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<B[log2(DATA_W)-1:0]; 7 SHR logical, same amount; 8 STO R[dest] <= {src1,src0} zero-extended/truncated to DATA_W; 9 JMP IP <= dest zero-extended; 10 BLE branch to dest if A ≤ B unsigned; 11 BEQ branch if A == B; 12 LED oLed <= A[7:0]; 13 OUT send A[7:0]; 14 SLT R[dest] <= (A < B unsigned) ? 1 : 0; 15 HALT.
- Arithmetic modulo 2**DATA_W; no flags, no carry.
- Taken branch/JMP: IP <= target, IR <= NOP (flushes the already-fetched instruction); not-taken costs nothing.
- OUT: while IR is OUT, oPeriphValid = 1, oPeriphData = A[7:0] (stable). IP, IR, register file held. Completes on the edge where iPeriphReady = 1; normal fetch occurs on that edge.
- HALT: IP and IR frozen, oHalted = 1 until Reset; no further writes.
- Register file has no reset; software initialises with STO.

## Timing
- Reset asserted: oIP = 0, IR = NOP, oLed = 0, oPeriphValid = 0, oPeriphData = 0, oHalted = 0, immediately (async).
- After release, edge 1: IR <= ROM[0], IP = 1. Edge 2: executes ROM[0]. Latency fetch→result = 2 edges; throughput 1 instr/cycle.
- Taken branch: 1 bubble cycle; target instruction executes 2 edges after the branch executes.
- oPeriphValid/oPeriphData decoded from IR only (no combinational path from iPeriphReady). Ready high on the first valid cycle → zero stall cycles; each cycle ready low adds one.
- Ready while not valid is ignored.
- Reset mid-stall: valid drops asynchronously; byte is not considered sent.
- IP wrap at 2**IP_W−1 → 0, no exception.

## Test plan
- Reset/boot: hold Reset=0, check all outputs at reset values; release, ROM = {STO r1,0x0005; STO r2,0x0003; ADD r3,r1,r2; LED r3} → oLed = 0x08 after 5 edges, oIP increments 0,1,2,…
- Branch loop: r1=0, r2=1, r3=4; loop ADD r1,r1,r2; BLE→loop while r1≤r3 → exits with r1 = 5; verify one bubble per taken branch and oIP = target the cycle after.
- Stall: OUT r1 with r1=0x41, ready held low 3 cycles → oPeriphValid high 4 cycles, data 0x41, oIP constant; ready high → next instruction executes next edge.
- ALU corners (DATA_W=16): 0x0000−1 = 0xFFFF; SHL 0x0001 by 15 = 0x8000; SHL amount 0x0011 uses 1 → 0x0002; SLT 3,5 = 1; BEQ equal taken.
- HALT and async reset: HALT → oHalted = 1, oIP frozen 10 cycles; assert Reset mid-OUT stall → oPeriphValid = 0 before next edge.
- Parameter sweep: DATA_W=8, ADDR_W=4, IP_W=8 → STO truncation {src1,src0}=0xA5 stored as 0xA5, IP wrap 0xFF→0x00.

Source files
------------

// File: rtl/mini_alu_core_if.sv
`default_nettype none
// ============================================================================
// mini_alu_core_if : instruction-ROM, LED and byte-peripheral bus of the core
// Revision 1.0
// ============================================================================
interface mini_alu_core_if #(
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16
) ();

  localparam int INSN_W = 4 + 3 * ADDR_W;

  logic [IP_W-1:0]   ip;
  logic [INSN_W-1:0] instruction;
  logic [7:0]        led;
  logic [7:0]        periph_data;
  logic              periph_valid;
  logic              periph_ready;
  logic              halted;

  modport master (
    output ip,
    output led,
    output periph_data,
    output periph_valid,
    output halted,
    input  instruction,
    input  periph_ready
  );

  modport slave (
    input  ip,
    input  led,
    input  periph_data,
    input  periph_valid,
    input  halted,
    output instruction,
    output periph_ready
  );

endinterface
`default_nettype wire

// File: rtl/mini_alu_core.sv
`default_nettype none
// ============================================================================
// mini_alu_core : two-stage fetch/execute register machine with LED and a
//                 valid/ready byte peripheral port.   Revision 1.0
// ============================================================================
module mini_alu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  mini_alu_core_if.master bus_if
);

  localparam int INSN_W   = 4 + 3 * ADDR_W;
  localparam int SH_W     = $clog2(DATA_W);
  localparam int RF_DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_STO  = 4'd8,
    OP_JMP  = 4'd9,
    OP_BLE  = 4'd10,
    OP_BEQ  = 4'd11,
    OP_LED  = 4'd12,
    OP_OUT  = 4'd13,
    OP_SLT  = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  logic [IP_W-1:0]     ip_q, ip_d;
  logic [INSN_W-1:0]   ir_q, ir_d;
  logic [7:0]          led_q, led_d;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];

  opcode_e             opcode;
  logic [ADDR_W-1:0]   dest, src1, src0;
  logic [DATA_W-1:0]   op_a, op_b, alu_res;
  logic [SH_W-1:0]     shamt;
  logic [2*ADDR_W-1:0] imm;
  logic [IP_W-1:0]     target;
  logic                rf_we;
  logic                taken;
  logic                hold;

  assign opcode = opcode_e'(ir_q[INSN_W-1 -: 4]);
  assign dest   = ir_q[3*ADDR_W-1 -: ADDR_W];
  assign src1   = ir_q[2*ADDR_W-1 -: ADDR_W];
  assign src0   = ir_q[ADDR_W-1:0];

  assign op_a   = rf_q[src1];
  assign op_b   = rf_q[src0];
  assign shamt  = op_b[SH_W-1:0];
  assign imm    = {src1, src0};
  assign target = IP_W'(dest);

  always_comb begin : p_execute
    alu_res = '0;
    rf_we   = 1'b0;
    taken   = 1'b0;
    led_d   = led_q;
    case (opcode)
      OP_ADD: begin alu_res = op_a + op_b;    rf_we = 1'b1; end
      OP_SUB: begin alu_res = op_a - op_b;    rf_we = 1'b1; end
      OP_AND: begin alu_res = op_a & op_b;    rf_we = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b;    rf_we = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b;    rf_we = 1'b1; end
      OP_SHL: begin alu_res = op_a << shamt;  rf_we = 1'b1; end
      OP_SHR: begin alu_res = op_a >> shamt;  rf_we = 1'b1; end
      OP_STO: begin alu_res = DATA_W'(imm);   rf_we = 1'b1; end
      OP_SLT: begin
        alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
        rf_we   = 1'b1;
      end
      OP_JMP: taken = 1'b1;
      OP_BLE: taken = (op_a <= op_b);
      OP_BEQ: taken = (op_a == op_b);
      OP_LED: led_d = op_a[7:0];
      default: ;
    endcase
  end

  // A pending OUT and HALT both freeze fetch; a taken branch squashes the
  // instruction fetched behind it by loading a NOP into IR.
  assign hold = ((opcode == OP_OUT) && !bus_if.periph_ready) || (opcode == OP_HALT);

  always_comb begin : p_fetch
    ip_d = ip_q + IP_W'(1);
    ir_d = bus_if.instruction;
    if (hold) begin
      ip_d = ip_q;
      ir_d = ir_q;
    end else if (taken) begin
      ip_d = target;
      ir_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
    if (!rst_ni) begin
      ip_q  <= '0;
      ir_q  <= '0;
      led_q <= '0;
    end else begin
      ip_q  <= ip_d;
      ir_q  <= ir_d;
      led_q <= led_d;
    end
  end

  always_ff @(posedge clk_i) begin : p_regfile
    if (rf_we) begin
      rf_q[dest] <= alu_res;
    end
  end

  // Peripheral and halt outputs decode IR only, so reset drops them at once.
  assign bus_if.ip           = ip_q;
  assign bus_if.led          = led_q;
  assign bus_if.periph_valid = (opcode == OP_OUT);
  assign bus_if.periph_data  = (opcode == OP_OUT) ? op_a[7:0] : 8'h00;
  assign bus_if.halted       = (opcode == OP_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_core.sv
`default_nettype none
// ============================================================================
// tb_mini_alu_core : directed programs with hand-computed results for the
//                    default core and an 8-bit / 4-bit / 8-bit variant.
// ============================================================================
module tb_mini_alu_core;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [27:0] rom  [256];
  logic [15:0] rom8 [256];

  mini_alu_core_if #(.ADDR_W(8), .IP_W(16)) bus  ();
  mini_alu_core_if #(.ADDR_W(4), .IP_W(8))  bus8 ();

  assign bus.instruction  = rom[bus.ip[7:0]];
  assign bus8.instruction = rom8[bus8.ip];

  mini_alu_core #(.DATA_W(16), .ADDR_W(8), .IP_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus)
  );

  mini_alu_core #(.DATA_W(8), .ADDR_W(4), .IP_W(8)) dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] v);
    return {4'd8, d, v};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = '0;
      rom8[i] = '0;
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_rom();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = sto(8'd1, 16'h0005);
    rom[1] = sto(8'd2, 16'h0003);
    rom[2] = ins(4'd1, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(4'd12, 8'd0, 8'd3, 8'd0);
    bus.periph_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.ip !== 16'h0000) begin n_err++; $display("FAIL reset_ip got=%h exp=0000", bus.ip); end
    n_vec++; if (bus.led !== 8'h00) begin n_err++; $display("FAIL reset_led got=%h exp=00", bus.led); end
    n_vec++; if (bus.periph_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.periph_valid); end
    n_vec++; if (bus.periph_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", bus.periph_data); end
    n_vec++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
  endtask

  task automatic test_boot();
    release_reset();
    n_vec++; if (bus.ip !== 16'd0) begin n_err++; $display("FAIL boot_ip0 got=%h exp=0000", bus.ip); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.ip !== 16'(k)) begin n_err++; $display("FAIL boot_ip edge=%0d got=%h exp=%h", k, bus.ip, 16'(k)); end
      if (k == 4) begin
        n_vec++; if (bus.led !== 8'h00) begin n_err++; $display("FAIL boot_led_early got=%h exp=00", bus.led); end
      end
      if (k == 5) begin
        n_vec++; if (bus.led !== 8'h08) begin n_err++; $display("FAIL boot_led got=%h exp=08", bus.led); end
      end
    end
  endtask

  task automatic test_branch();
    int exp_ip [19] = '{1, 2, 3, 4, 5, 3, 4, 5, 3, 4, 5, 3, 4, 5, 3, 4, 5, 6, 7};
    hold_reset();
    rom[0] = sto(8'd1, 16'd0);
    rom[1] = sto(8'd2, 16'd1);
    rom[2] = sto(8'd3, 16'd4);
    rom[3] = ins(4'd1, 8'd1, 8'd1, 8'd2);
    rom[4] = ins(4'd10, 8'd3, 8'd1, 8'd3);
    rom[5] = ins(4'd12, 8'd0, 8'd1, 8'd0);
    rom[6] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    release_reset();
    for (int e = 0; e < 19; e++) begin
      @(negedge clk);
      n_vec++;
      if (bus.ip !== 16'(exp_ip[e])) begin
        n_err++; $display("FAIL branch_ip edge=%0d got=%h exp=%h", e + 1, bus.ip, 16'(exp_ip[e]));
      end
      if (e == 17) begin
        n_vec++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL branch_halt_early got=%b exp=0", bus.halted); end
        n_vec++; if (bus.led !== 8'h00) begin n_err++; $display("FAIL branch_led_early got=%h exp=00", bus.led); end
      end
      if (e == 18) begin
        n_vec++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL branch_halt got=%b exp=1", bus.halted); end
        n_vec++; if (bus.led !== 8'h05) begin n_err++; $display("FAIL branch_led got=%h exp=05", bus.led); end
      end
    end
  endtask

  task automatic test_stall();
    hold_reset();
    rom[0] = sto(8'd1, 16'h0041);
    rom[1] = ins(4'd13, 8'd0, 8'd1, 8'd0);
    rom[2] = sto(8'd2, 16'h0007);
    rom[3] = ins(4'd12, 8'd0, 8'd2, 8'd0);
    bus.periph_ready = 1'b1;
    release_reset();
    @(negedge clk);
    @(negedge clk);
    bus.periph_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      n_vec++; if (bus.periph_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, bus.periph_valid); end
      n_vec++; if (bus.periph_data !== 8'h41) begin n_err++; $display("FAIL stall_data cyc=%0d got=%h exp=41", c, bus.periph_data); end
      n_vec++; if (bus.ip !== 16'd2) begin n_err++; $display("FAIL stall_ip cyc=%0d got=%h exp=0002", c, bus.ip); end
      if (c == 3) bus.periph_ready = 1'b1;
    end
    @(negedge clk);
    n_vec++; if (bus.periph_valid !== 1'b0) begin n_err++; $display("FAIL stall_done_valid got=%b exp=0", bus.periph_valid); end
    n_vec++; if (bus.ip !== 16'd3) begin n_err++; $display("FAIL stall_done_ip got=%h exp=0003", bus.ip); end
    @(negedge clk);
    n_vec++; if (bus.led !== 8'h00) begin n_err++; $display("FAIL stall_led_early got=%h exp=00", bus.led); end
    @(negedge clk);
    n_vec++; if (bus.led !== 8'h07) begin n_err++; $display("FAIL stall_led got=%h exp=07", bus.led); end
  endtask

  task automatic test_alu_corners();
    logic [7:0] exp_b [12] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 8'h02, 8'h01,
                               8'h00, 8'h3C, 8'hC3, 8'h3D, 8'h03, 8'h78};
    logic [7:0] got [$];
    bit done;
    hold_reset();
    rom[0]  = sto(8'd0, 16'h0000);
    rom[1]  = sto(8'd1, 16'h0001);
    rom[2]  = sto(8'd2, 16'h000F);
    rom[3]  = sto(8'd3, 16'h0011);
    rom[4]  = sto(8'd4, 16'h0003);
    rom[5]  = sto(8'd5, 16'h0005);
    rom[6]  = sto(8'd8, 16'h0008);
    rom[7]  = sto(8'd17, 16'h5A3C);
    rom[8]  = ins(4'd2,  8'd6,  8'd0,  8'd1);
    rom[9]  = ins(4'd13, 8'd0,  8'd6,  8'd0);
    rom[10] = ins(4'd7,  8'd7,  8'd6,  8'd8);
    rom[11] = ins(4'd13, 8'd0,  8'd7,  8'd0);
    rom[12] = ins(4'd6,  8'd9,  8'd1,  8'd2);
    rom[13] = ins(4'd13, 8'd0,  8'd9,  8'd0);
    rom[14] = ins(4'd7,  8'd10, 8'd9,  8'd8);
    rom[15] = ins(4'd13, 8'd0,  8'd10, 8'd0);
    rom[16] = ins(4'd6,  8'd11, 8'd1,  8'd3);
    rom[17] = ins(4'd13, 8'd0,  8'd11, 8'd0);
    rom[18] = ins(4'd14, 8'd12, 8'd4,  8'd5);
    rom[19] = ins(4'd13, 8'd0,  8'd12, 8'd0);
    rom[20] = ins(4'd14, 8'd13, 8'd5,  8'd4);
    rom[21] = ins(4'd13, 8'd0,  8'd13, 8'd0);
    rom[22] = ins(4'd3,  8'd14, 8'd6,  8'd17);
    rom[23] = ins(4'd13, 8'd0,  8'd14, 8'd0);
    rom[24] = ins(4'd5,  8'd15, 8'd17, 8'd6);
    rom[25] = ins(4'd13, 8'd0,  8'd15, 8'd0);
    rom[26] = ins(4'd4,  8'd16, 8'd17, 8'd1);
    rom[27] = ins(4'd13, 8'd0,  8'd16, 8'd0);
    rom[28] = ins(4'd11, 8'd31, 8'd4,  8'd4);
    rom[29] = ins(4'd13, 8'd0,  8'd5,  8'd0);
    rom[30] = ins(4'd13, 8'd0,  8'd5,  8'd0);
    rom[31] = ins(4'd11, 8'd40, 8'd4,  8'd5);
    rom[32] = ins(4'd13, 8'd0,  8'd4,  8'd0);
    rom[33] = ins(4'd1,  8'd18, 8'd17, 8'd17);
    rom[34] = ins(4'd13, 8'd0,  8'd18, 8'd0);
    rom[35] = ins(4'd15, 8'd0,  8'd0,  8'd0);
    bus.periph_ready = 1'b1;
    release_reset();
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.periph_valid === 1'b1) got.push_back(bus.periph_data);
      if (bus.halted === 1'b1) done = 1'b1;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL alu_halt_timeout got=0 exp=1"); end
    n_vec++; if (got.size() != 12) begin n_err++; $display("FAIL alu_byte_count got=%0d exp=12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (i >= got.size()) begin
        n_err++; $display("FAIL alu_byte idx=%0d got=none exp=%h", i, exp_b[i]);
      end else if (got[i] !== exp_b[i]) begin
        n_err++; $display("FAIL alu_byte idx=%0d got=%h exp=%h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++; if (bus.ip !== 16'd36) begin n_err++; $display("FAIL halt_ip cyc=%0d got=%h exp=0024", c, bus.ip); end
      n_vec++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_flag cyc=%0d got=%b exp=1", c, bus.halted); end
    end
  endtask

  task automatic test_reset_mid_stall();
    hold_reset();
    rom[0] = sto(8'd1, 16'h0041);
    rom[1] = ins(4'd13, 8'd0, 8'd1, 8'd0);
    bus.periph_ready = 1'b0;
    release_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (bus.periph_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.periph_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.periph_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", bus.periph_valid); end
    n_vec++; if (bus.periph_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got=%h exp=00", bus.periph_data); end
    n_vec++; if (bus.ip !== 16'd0) begin n_err++; $display("FAIL midrst_ip got=%h exp=0000", bus.ip); end
  endtask

  task automatic test_param_sweep();
    hold_reset();
    rom8[0] = {4'd8, 4'd1, 4'hA, 4'h5};
    rom8[1] = {4'd13, 4'd0, 4'd1, 4'd0};
    rom8[2] = {4'd12, 4'd0, 4'd1, 4'd0};
    release_reset();
    for (int e = 1; e <= 256; e++) begin
      @(negedge clk);
      if (e == 2) begin
        n_vec++; if (bus8.periph_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid got=%b exp=1", bus8.periph_valid); end
        n_vec++; if (bus8.periph_data !== 8'hA5) begin n_err++; $display("FAIL sweep_data got=%h exp=a5", bus8.periph_data); end
      end
      if (e == 3) begin
        n_vec++; if (bus8.ip !== 8'h03) begin n_err++; $display("FAIL sweep_ip3 got=%h exp=03", bus8.ip); end
      end
      if (e == 4) begin
        n_vec++; if (bus8.led !== 8'hA5) begin n_err++; $display("FAIL sweep_led got=%h exp=a5", bus8.led); end
      end
      if (e == 255) begin
        n_vec++; if (bus8.ip !== 8'hFF) begin n_err++; $display("FAIL sweep_ip_max got=%h exp=ff", bus8.ip); end
      end
      if (e == 256) begin
        n_vec++; if (bus8.ip !== 8'h00) begin n_err++; $display("FAIL sweep_ip_wrap got=%h exp=00", bus8.ip); end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.periph_ready  = 1'b0;
    bus8.periph_ready = 1'b1;
    test_reset();
    test_boot();
    test_branch();
    test_stall();
    test_alu_corners();
    test_halt();
    test_reset_mid_stall();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
